// File: rtl/bit_changer_seq.sv
// bit_changer_seq: SET/CLR/TGL/TST/FILL on an N-bit operand with a sign-magnitude index and valid/ready handshakes.
// Optional saturating error counter on o_err_cnt when BITCHG_ERRCNT_EN is defined.
module bit_changer_seq #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         o_ready,
   input  logic [2:0]   in_op,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   output logic         o_valid,
   input  logic         in_ready,
   output logic [N-1:0] o_out,
   output logic         o_bit,
   output logic         o_ERR,
   output logic [7:0]   o_err_cnt
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [2:0] OP_SET = 3'd0, OP_CLR = 3'd1, OP_TGL = 3'd2, OP_TST = 3'd3, OP_FILL = 3'd4;
   state_t        state_q, state_d;
   logic [N-1:0]  out_q, out_d;
   logic          bit_q, bit_d, err_q, err_d;
   logic [IW-1:0] idx_q, idx_d, mag_q, mag_d;
   logic [N-2:0]  mag;
   logic [IW-1:0] mag_idx;
   logic [N-1:0]  mask;
   logic          bad;
   assign mag     = in_b[N-2:0];
   assign mag_idx = mag[IW-1:0];
   assign mask    = N'(1) << mag_idx;
   assign bad     = in_b[N-1] || (mag >= (N-1)'(N)) || (in_op > OP_FILL);
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      bit_d   = bit_q;
      err_d   = err_q;
      idx_d   = idx_q;
      mag_d   = mag_q;
      if (state_q == IDLE && in_valid) begin
         mag_d   = mag_idx;
         idx_d   = '0;
         err_d   = bad;
         bit_d   = !bad && in_op == OP_TST && in_a[mag_idx];
         state_d = (bad || in_op != OP_FILL) ? DONE : BUSY;
         out_d   = bad              ? '0 :
                   in_op == OP_SET ? in_a | mask :
                   in_op == OP_CLR ? in_a & ~mask :
                   in_op == OP_TGL ? in_a ^ mask : in_a;
      end else if (state_q == BUSY) begin
         // FILL walks idx up from 0, setting one bit per cycle until it reaches mag
         out_d   = out_q | (N'(1) << idx_q);
         idx_d   = idx_q + 1'b1;
         state_d = (idx_q == mag_q) ? DONE : BUSY;
      end else if (state_q == DONE && in_ready) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         bit_q   <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         bit_q   <= bit_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         mag_q   <= mag_d;
      end
   end
   assign o_ready = state_q == IDLE;
   assign o_valid = state_q == DONE;
   assign o_out   = out_q;
   assign o_bit   = bit_q;
   assign o_ERR   = err_q;
`ifdef BITCHG_ERRCNT_EN
   logic [7:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = (state_q == IDLE && in_valid && bad && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end
   assign o_err_cnt = cnt_q;
`else
   assign o_err_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_bit_changer_seq.sv
// tb_bit_changer_seq: scoreboard bench for bit_changer_seq (N=8), directed plan cases plus randomized ops.
module tb_bit_changer_seq;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_valid = 1'b0, in_ready = 1'b1;
   logic [2:0] in_op = '0;
   logic [7:0] in_a = '0, in_b = '0;
   logic       o_ready, o_valid, o_bit, o_ERR;
   logic [7:0] o_out, o_err_cnt;
   int checks = 0, errors = 0, model_cnt = 0;
   logic hold_en = 1'b1, hold_val = 1'b1;
   typedef struct {logic [7:0] out; logic b; logic err;} exp_t;
   exp_t q[$];

   bit_changer_seq #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .o_ready(o_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .o_valid(o_valid), .in_ready(in_ready), .o_out(o_out),
      .o_bit(o_bit), .o_ERR(o_ERR), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   m;
      m = int'(b[6:0]);
      e.out = 8'h00; e.b = 1'b0; e.err = 1'b0;
      if (b[7] || m >= 8 || op > 3'd4) e.err = 1'b1;
      else if (op == 3'd0) e.out = a | 8'(1 << m);
      else if (op == 3'd1) e.out = a & ~8'(1 << m);
      else if (op == 3'd2) e.out = a ^ 8'(1 << m);
      else if (op == 3'd3) begin e.out = a; e.b = a[m]; end
      else e.out = a | 8'((1 << (m + 1)) - 1);
      return e;
   endfunction

   function automatic logic [7:0] exp_cnt();
`ifdef BITCHG_ERRCNT_EN
      return 8'(model_cnt);
`else
      return 8'd0;
`endif
   endfunction

   always @(posedge clk) begin
      #1;
      in_ready = hold_en ? hold_val : ($urandom_range(0, 3) != 0);
   end

   task automatic wait_ready();
      int n = 0;
      do begin @(negedge clk); n++; end while (!o_ready && n < 200);
      if (!o_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   lat, want;
      wait_ready();
      e = model(op, a, b);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      q.push_back(e);
      if (e.err && model_cnt < 255) model_cnt++;
      want = (e.err || op != 3'd4) ? 1 : int'(b[6:0]) + 2;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      lat = 0;
      do begin
         @(negedge clk); lat++;
         if (!o_valid) chk("busy_ready", o_ready, 0);
      end while (!o_valid && lat < 100);
      chk("latency", lat, want);
   endtask

   logic       held = 1'b0, rel = 1'b0;
   logic [7:0] p_out;
   logic       p_bit, p_err;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0; rel = 1'b0;
      end else begin
         if (held) begin
            chk("hold_out", o_out, p_out);
            chk("hold_bit", o_bit, p_bit);
            chk("hold_err", o_ERR, p_err);
            chk("hold_valid", o_valid, 1);
            chk("hold_ready", o_ready, 0);
         end
         if (rel) begin
            chk("rel_valid", o_valid, 0);
            chk("rel_ready", o_ready, 1);
         end
         held = o_valid && !in_ready;
         rel  = o_valid && in_ready;
         p_out = o_out; p_bit = o_bit; p_err = o_ERR;
         if (o_valid && in_ready) begin
            if (q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("out", o_out, e.out);
               chk("bit", o_bit, e.b);
               chk("err", o_ERR, e.err);
            end
         end
      end
   end

   initial begin
      #2;
      chk("rst_valid", o_valid, 0);
      chk("rst_out", o_out, 0);
      chk("rst_bit", o_bit, 0);
      chk("rst_err", o_ERR, 0);
      chk("rst_cnt", o_err_cnt, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", o_ready, 1);
      issue(3'd0, 8'h00, 8'd3);
      issue(3'd1, 8'hFF, 8'd7);
      issue(3'd2, 8'hA5, 8'd0);
      issue(3'd3, 8'h10, 8'd4);
      issue(3'd3, 8'h10, 8'd5);
      issue(3'd0, 8'h00, 8'h83);
      issue(3'd0, 8'h00, 8'd8);
      issue(3'd7, 8'h00, 8'd0);
      chk("cnt_three", o_err_cnt, exp_cnt());
      issue(3'd4, 8'h80, 8'd3);
      issue(3'd4, 8'h00, 8'd0);
      issue(3'd4, 8'h00, 8'd7);
      hold_val = 1'b0;
      issue(3'd0, 8'h55, 8'd1);
      repeat (10) @(negedge clk);
      hold_val = 1'b1;
      hold_en = 1'b0;
      repeat (300) begin
         logic [2:0] op;
         logic [7:0] b;
         op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         b  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
         issue(op, 8'($urandom), b);
      end
      hold_en = 1'b1; hold_val = 1'b1;
      repeat (300) issue(3'($urandom), 8'($urandom), 8'h80 | 8'($urandom));
      chk("cnt_sat", o_err_cnt, exp_cnt());
      wait_ready();
      in_valid = 1'b1; in_op = 3'd4; in_a = 8'h00; in_b = 8'd7;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_valid", o_valid, 0);
      chk("abort_out", o_out, 0);
      model_cnt = 0;
      chk("abort_cnt", o_err_cnt, exp_cnt());
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("abort_ready", o_ready, 1);
      issue(3'd0, 8'h00, 8'd5);
      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bit_changer_seq.md
Name: bit_changer_seq

Overview:
- Sequential, parametrised successor to the combinational single-bit setter.
- Applies one of five bit operations to an N-bit operand: SET, CLR, TGL, TST, or serial FILL.
- The bit index is a sign-magnitude operand, range-checked; illegal indices raise an error.
- Sits between the operand register file and the result bus, with a valid/ready handshake on both sides.

Parameters:
- N, 8: operand width in bits. Legal values are 4 to 64.
- IW, $clog2(N): width of the internal bit-index counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an operation.
- o_ready  out  1  block can accept an operation.
- in_op  in  3  opcode: 000 SET, 001 CLR, 010 TGL, 011 TST, 100 FILL. Codes 101 to 111 are illegal.
- in_a  in  N  operand.
- in_b  in  N  bit index, sign-magnitude. in_b[N-1] is the sign; in_b[N-2:0] is the magnitude.
- o_valid  out  1  result is available.
- in_ready  in  1  downstream accepts the result.
- o_out  out  N  result word.
- o_bit  out  1  tested bit (TST only; 0 for all other ops).
- o_ERR  out  1  the operation was rejected.
- o_err_cnt  out  8  error counter. Driven only when the optional feature is compiled in.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - o_valid=0, o_out=0, o_bit=0, o_ERR=0, o_err_cnt=0.
  - o_ready=1 once reset is released.
  - Reset during BUSY or DONE aborts the operation; no result is emitted.
- Let mag = in_b[N-2:0] and sign = in_b[N-1].
- Error condition:
  - sign=1, or mag >= N, or an illegal opcode.
  - Index N itself is an error.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - o_ready=1.
  - Accept happens on in_valid && o_ready at rising edge k.
  - On accept, the operands are latched, so input changes after acceptance have no effect.
  - Error: go to DONE. o_out=0, o_bit=0, o_ERR=1.
  - SET: o_out = in_a with bit mag forced to 1. Go to DONE.
  - CLR: o_out = in_a with bit mag forced to 0. Go to DONE.
  - TGL: o_out = in_a with bit mag inverted. Go to DONE.
  - TST: o_out=in_a, o_bit=in_a[mag]. Go to DONE.
  - FILL: load the result register with in_a, set idx=0, go to BUSY.
  - For SET/CLR/TGL/TST/error, o_valid rises at cycle k+1 (1-cycle latency).
- BUSY (FILL only):
  - o_ready=0 and o_valid=0.
  - Each cycle sets result bit idx, then idx increments.
  - When idx==mag, that bit is set and the state goes to DONE.
  - FILL therefore takes mag+1 BUSY cycles; o_valid rises at cycle k+mag+2.
  - FILL with mag=0 sets bit 0 only.
  - idx never exceeds N-1, because mag is checked before entry.
- DONE:
  - o_valid=1 and o_ready=0.
  - o_out, o_bit and o_ERR are held stable while in_ready=0 (backpressure of any length).
  - On in_ready=1: return to IDLE and drop o_valid the next cycle.
  - No new op is accepted in the same cycle as the result is released.
  - Back-to-back throughput is therefore 1 op per 2 cycles for the single-step ops.
- o_out, o_bit and o_ERR are registered and glitch-free. Their values are meaningful only while o_valid=1.

Optional Feature:
- Macro: BITCHG_ERRCNT_EN.
- Defined:
  - o_err_cnt is an 8-bit saturating counter.
  - It increments on each accepted op that raises o_ERR.
  - It holds at 255.
  - It is cleared only by rst_n.
- Not defined:
  - No counter logic is generated.
  - o_err_cnt is tied to 0.

Test Plan:
- Simple ops, N=8:
  - SET, in_a=8'h00, in_b=8'd3 -> one cycle after accept: o_valid=1, o_out=8'h08, o_ERR=0.
  - CLR, in_a=8'hFF, in_b=8'd7 -> o_out=8'h7F.
  - TGL, in_a=8'hA5, in_b=8'd0 -> o_out=8'hA4.
- TST: in_a=8'h10, in_b=8'd4 -> o_bit=1, o_out=8'h10. Then in_b=8'd5 -> o_bit=0.
- Errors:
  - in_b=8'h83 (sign set) -> o_ERR=1, o_out=0.
  - in_b=8'd8 -> o_ERR=1.
  - in_op=3'b111 -> o_ERR=1.
  - With BITCHG_ERRCNT_EN defined, o_err_cnt=3 after all three.
  - 300 errors -> o_err_cnt=255.
- FILL: in_a=8'h80, in_b=8'd3, accepted at cycle k -> o_ready=0 for cycles k+1 to k+5, o_valid at k+5, o_out=8'h8F.
- Backpressure: hold in_ready=0 for 10 cycles in DONE -> o_out stable, o_ready=0. Then in_ready=1 -> o_valid=0 next cycle, o_ready=1.
- Reset abort: FILL with in_b=8'd7, assert rst_n=0 mid-BUSY -> o_valid=0, o_out=0 immediately (async). After release, o_ready=1 and a SET completes normally.
